sync_to_dualrail_injector: RTL and testbench

- Clocked producer stage that sits directly upstream of the 8-bit asynchronous dual-rail buffer stage.
- Accepts 8-bit binary tokens on a synchronous valid/ready interface.
- Encodes each token into a 16-wire dual-rail codeword and runs the four-phase return-to-zero handshake against the buffer's asynchronous ack.
- Bridges the clocked test/IO domain into the asynchronous datapath.

---
 rtl/sync_to_dualrail_injector_pkg.sv | 26 ++
 rtl/sync_to_dualrail_injector_sync_ff_chain.sv | 26 ++
 rtl/sync_to_dualrail_injector.sv | 121 ++++++++++++
 tb/tb_sync_to_dualrail_injector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_to_dualrail_injector_pkg.sv
// Shared definitions for the clocked-to-dual-rail injector: FSM state
// encoding, rail constants and the binary-to-dual-rail encoder.
package sync_to_dualrail_injector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RTZ  = 2'd2
  } state_t;

  localparam logic [1:0]  RAIL_ONE    = 2'b10;
  localparam logic [1:0]  RAIL_ZERO   = 2'b01;
  localparam logic [1:0]  RAIL_SPACER = 2'b00;
  localparam logic [15:0] SPACER_WORD = {8{RAIL_SPACER}};

  // Bit i of the token drives rail pair {word[2i+1], word[2i]}.
  function automatic logic [15:0] dr_encode(input logic [7:0] bin);
    logic [15:0] word;
    word = SPACER_WORD;
    for (int i = 0; i < 8; i++) begin
      word[2*i +: 2] = bin[i] ? RAIL_ONE : RAIL_ZERO;
    end
    return word;
  endfunction

endpackage

// File: rtl/sync_to_dualrail_injector_sync_ff_chain.sv
// Multi-flop synchroniser for a single signal that is asynchronous to clk.
module sync_ff_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the asynchronous input through the chain; reset empties it.
  always_ff @(posedge clk) begin
    // NOTE: rst_n is sampled on the clock edge, so it belongs inside the
    // clocked block and is not in the sensitivity list.
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_to_dualrail_injector.sv
// Clocked producer that encodes 8-bit tokens as dual-rail codewords and runs
// the four-phase return-to-zero handshake against an asynchronous ack.
module sync_to_dualrail_injector
  import sync_to_dualrail_injector_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] data_out,
  input  logic        ack_in,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] tok_count
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_data_out;
  logic [15:0]     r_tok_count;
  logic [CW-1:0]   r_to_cnt;
  logic            r_err_timeout;
  logic            w_ack_s;
  logic            w_armed;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_ack_done;

  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (w_ack_s)
  );

  // A chain fed with constant 1 fills in step with the ack synchroniser, so
  // in_ready is held off until ack_s reflects the real ack after reset.
  sync_ff_chain #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (w_armed)
  );

  assign w_in_ready = (r_state == IDLE) && w_armed && !w_ack_s;

  // Next-state and handshake decisions, all based on the synchronised ack.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ack_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && w_in_ready) begin
          w_accept     = 1'b1;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_ack_s) begin
          w_ack_done   = 1'b1;
          w_state_next = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, codeword and token counter registers.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register updates
    // from pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data_out  <= SPACER_WORD;
      r_tok_count <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data_out <= dr_encode(in_data);
      end else if (w_ack_done) begin
        r_data_out  <= SPACER_WORD;
        r_tok_count <= r_tok_count + 16'd1;
      end
    end
  end

  // Watchdog on the DATA and RTZ waits; the error flag is sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else if (w_state_next != r_state) begin
      r_to_cnt <= '0;
    end else if (TO_EN && (r_state != IDLE) && (r_to_cnt != TO_MAX)) begin
      r_to_cnt <= r_to_cnt + CW'(1);
      if (r_to_cnt == TO_LAST) r_err_timeout <= 1'b1;
    end
  end

  assign in_ready    = w_in_ready;
  assign data_out    = r_data_out;
  assign busy        = (r_state != IDLE);
  assign err_timeout = r_err_timeout;
  assign tok_count   = r_tok_count;

endmodule

// File: tb/tb_sync_to_dualrail_injector.sv
// Directed and randomized bench for sync_to_dualrail_injector with a
// behavioural downstream buffer and a reference token model.
module tb_sync_to_dualrail_injector;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_out;
  logic        ack_in;
  logic        busy;
  logic        err_timeout;
  logic [15:0] tok_count;

  logic        auto_mode;
  logic        ack_auto;
  logic        ack_man;
  logic        mon_en;
  int          hi_run;
  int          lo_run;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_tok;

  assign ack_in = auto_mode ? ack_auto : ack_man;

  sync_to_dualrail_injector #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .err_timeout (err_timeout),
    .tok_count   (tok_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: 2 per one-bit, 1 per zero-bit, weighted by 4^i.
  function automatic logic [15:0] model_enc(input logic [7:0] b);
    int w;
    w = 0;
    for (int i = 0; i < 8; i++) w += (((b >> i) & 1) != 0 ? 2 : 1) * (4 ** i);
    return 16'(w);
  endfunction

  // Downstream buffer: ack rises 3 clocks into a codeword, falls 3 clocks
  // into a spacer.
  always @(posedge clk) begin
    #2;
    if (!auto_mode) begin
      ack_auto = 1'b0;
      hi_run   = 0;
      lo_run   = 0;
    end else if (data_out !== 16'h0000) begin
      lo_run = 0;
      hi_run++;
      if (hi_run == 3) ack_auto = 1'b1;
    end else begin
      hi_run = 0;
      lo_run++;
      if (lo_run == 3) ack_auto = 1'b0;
    end
  end

  // No rail pair may ever carry 2'b11.
  always @(negedge clk) begin
    if (mon_en) begin
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) if (data_out[2*i +: 2] === 2'b11) bad = 1'b1;
      check("pair_11", bad, 1'b0);
    end
  end

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clk);
    check(tag, in_ready, 1'b1);
  endtask

  task automatic wait_spacer(input string tag);
    for (int i = 0; i < 100 && data_out !== 16'h0000; i++) @(negedge clk);
    check(tag, data_out, 16'h0000);
  endtask

  // Present a token, wait for acceptance, check the codeword on the
  // accepting edge. in_valid is left high for the caller to manage.
  task automatic accept(input logic [7:0] tok, input string tag);
    in_data  = tok;
    in_valid = 1'b1;
    wait_ready({tag, "_ready"});
    check({tag, "_idle_spacer"}, data_out, 16'h0000);
    @(negedge clk);
    check({tag, "_code"}, data_out, model_enc(tok));
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_nready"}, in_ready, 1'b0);
  endtask

  task automatic complete(input string tag);
    wait_spacer({tag, "_spacer"});
    wait_ready({tag, "_done"});
    exp_tok = exp_tok + 16'd1;
    check({tag, "_tok"}, tok_count, exp_tok);
  endtask

  initial begin
    logic [7:0] stream [3];
    logic [7:0] tok;
    int         n;
    stream    = '{8'h00, 8'hFF, 8'h80};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    auto_mode = 1'b1;
    ack_auto  = 1'b0;
    ack_man   = 1'b0;
    mon_en    = 1'b0;
    hi_run    = 0;
    lo_run    = 0;
    exp_tok   = 16'h0000;

    // Reset state, then in_ready two clocks after release.
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_data", data_out, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_tok", tok_count, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", in_ready, 1'b1);
    check("idle_data", data_out, 16'h0000);
    check("idle_busy", busy, 1'b0);
    check("idle_tok", tok_count, 16'h0000);

    // Single token 0xA5 with spacer latency measured from ack_in rising.
    accept(8'hA5, "a5");
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 50 && ack_in !== 1'b1; i++) @(negedge clk);
    check("a5_ack_seen", ack_in, 1'b1);
    check("a5_held", data_out, 16'h9966);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_out !== 16'h0000 && n < 50);
    check("a5_spacer_lat", n, SYNC + 1);
    complete("a5");

    // Stream with in_valid held high throughout.
    foreach (stream[k]) begin
      accept(stream[k], $sformatf("stream%0d", k));
      if (k > 0) exp_tok = exp_tok + 16'd1;
    end
    in_valid = 1'b0;
    complete("stream_last");

    // Randomized tokens.
    for (int k = 0; k < 12; k++) begin
      tok = 8'($urandom);
      accept(tok, $sformatf("rnd%0d", k));
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      complete($sformatf("rnd%0d", k));
    end

    // Timeout: ack withheld in DATA.
    auto_mode = 1'b0;
    ack_man   = 1'b0;
    accept(8'h3C, "to");
    in_valid = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    check("to_err_early", err_timeout, 1'b0);
    @(negedge clk);
    check("to_err_set", err_timeout, 1'b1);
    check("to_data_held", data_out, 16'h5AA5);
    check("to_busy", busy, 1'b1);
    ack_man = 1'b1;
    wait_spacer("to_spacer");
    ack_man = 1'b0;
    wait_ready("to_ready");
    exp_tok = exp_tok + 16'd1;
    check("to_tok", tok_count, exp_tok);
    check("to_err_sticky", err_timeout, 1'b1);

    // Reset mid-handshake with a stale ack held high.
    tok = 8'($urandom);
    accept(tok, "mid");
    in_valid = 1'b0;
    ack_man  = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    exp_tok = 16'h0000;
    check("mid_rst_data", data_out, 16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_err", err_timeout, 1'b0);
    check("mid_rst_tok", tok_count, exp_tok);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("mid_stale%0d", i), in_ready, 1'b0);
    end
    ack_man = 1'b0;
    @(negedge clk);
    check("mid_sync_wait", in_ready, 1'b0);
    @(negedge clk);
    check("mid_ready_back", in_ready, 1'b1);
    auto_mode = 1'b1;
    accept(8'h5A, "post");
    in_valid = 1'b0;
    complete("post");

    // tok_count wraps from 16'hFFFF.
    force dut.r_tok_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_tok_count;
    exp_tok = 16'hFFFF;
    check("wrap_pre", tok_count, exp_tok);
    accept(8'hC3, "wrap");
    in_valid = 1'b0;
    complete("wrap");
    check("wrap_zero", tok_count, 16'h0000);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
